sw_debounce: RTL and testbench

Per-bit debouncer for the 16 board slide switches. It synchronises the raw asynchronous pad inputs into `clk_i`, filters contact bounce with per-bit stability counters, and presents a clean, registered switch word. It also raises a one-cycle change strobe with a per-bit mask. It sits between the switch pads and the switch interrupt controller: `db_o` drives that controller's debounced input.

---
 rtl/sw_pkg.sv | 16 +
 rtl/sw_debounce_bit.sv | 66 ++++++
 rtl/sw_debounce.sv | 82 ++++++++
 tb/tb_sw_debounce.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared constants and per-bit state type for the slide-switch debouncer.
// Optional prescaled advance is enabled with the SW_DEBOUNCE_TICK_EN macro.
package sw_pkg;

   localparam int unsigned SW_WIDTH              = 16;
   localparam int unsigned SW_STABLE_CNT_DEFAULT = 1_000_000;
   localparam int unsigned SW_TICK_DIV_DEFAULT   = 100_000;

   // IDLE: synchronised input agrees with the debounced value.
   // SETTLING: they differ and the stability counter is running.
   typedef enum logic {
      IDLE     = 1'b0,
      SETTLING = 1'b1
   } sw_bit_state_e;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, stability counter and debounced flop.
// db_next_o exposes the value db_o takes on the next edge so the top can
// build the change strobe in the same cycle the bit updates.
module sw_debounce_bit
   import sw_pkg::*;
#(
   parameter int unsigned STABLE_CNT = SW_STABLE_CNT_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic adv_i,
   input  logic raw_i,
   output logic db_o,
   output logic db_next_o
);

   localparam int unsigned CW = $clog2(STABLE_CNT);

   logic          s1_q, s1_d;
   logic          s2_q, s2_d;
   logic          db_q, db_d;
   logic [CW-1:0] cnt_q, cnt_d;
   sw_bit_state_e state;

   // Next-state: clear the counter while in agreement, count advances otherwise.
   always_comb begin
      s1_d  = raw_i;
      s2_d  = s1_q;
      db_d  = db_q;
      cnt_d = cnt_q;
      state = (s2_q == db_q) ? IDLE : SETTLING;
      case (state)
         IDLE: cnt_d = '0;
         SETTLING: begin
            if (adv_i) begin
               if (cnt_q == CW'(STABLE_CNT - 1)) begin
                  db_d  = s2_q;
                  cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: cnt_d = '0;
      endcase
   end

   // State registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         db_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         db_q  <= db_d;
         cnt_q <= cnt_d;
      end
   end

   assign db_o      = db_q;
   assign db_next_o = db_d;

endmodule

// File: rtl/sw_debounce.sv
// Per-bit debouncer for the board slide switches, feeding the switch
// interrupt controller. Define SW_DEBOUNCE_TICK_EN to advance the stability
// counters on a shared prescaler tick instead of every clock.
module sw_debounce
   import sw_pkg::*;
#(
   parameter int unsigned WIDTH      = SW_WIDTH,
   parameter int unsigned STABLE_CNT = SW_STABLE_CNT_DEFAULT,
   parameter int unsigned TICK_DIV   = SW_TICK_DIV_DEFAULT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] db_o,
   output logic             chg_o,
   output logic [WIDTH-1:0] chg_mask_o
);

   logic             adv;
   logic [WIDTH-1:0] db;
   logic [WIDTH-1:0] db_next;
   logic             chg_q, chg_d;
   logic [WIDTH-1:0] chg_mask_q, chg_mask_d;

`ifdef SW_DEBOUNCE_TICK_EN
   localparam int unsigned PW = $clog2(TICK_DIV);

   logic [PW-1:0] pre_q, pre_d;
   logic          tick;

   // Prescaler: ticks on its terminal count, then wraps to zero.
   always_comb begin
      tick  = (pre_q == PW'(TICK_DIV - 1));
      pre_d = tick ? '0 : pre_q + PW'(1);
   end

   // Prescaler register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) pre_q <= '0;
      else       pre_q <= pre_d;
   end

   assign adv = tick;
`else
   assign adv = 1'b1;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sw_debounce_bit #(
         .STABLE_CNT (STABLE_CNT)
      ) u_bit (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .adv_i      (adv),
         .raw_i      (raw_i[i]),
         .db_o       (db[i]),
         .db_next_o  (db_next[i])
      );
   end

   // Change strobe: bits whose debounced value flips on this edge.
   always_comb begin
      chg_mask_d = db_next ^ db;
      chg_d      = |chg_mask_d;
   end

   // Strobe registers, updated on the same edge as the debounced bits.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         chg_q      <= 1'b0;
         chg_mask_q <= '0;
      end else begin
         chg_q      <= chg_d;
         chg_mask_q <= chg_mask_d;
      end
   end

   assign db_o       = db;
   assign chg_o      = chg_q;
   assign chg_mask_o = chg_mask_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: reset values, table of clean changes (single,
// simultaneous, opposite-direction), bounce rejection and reset mid-count.
module tb_sw_debounce;

   localparam int W      = 16;
   localparam int SC     = 4;
   localparam int TD     = 3;
`ifdef SW_DEBOUNCE_TICK_EN
   localparam int LO     = 12;
   localparam int HI     = 14;
`else
   localparam int LO     = SC + 2;
   localparam int HI     = SC + 2;
`endif
   localparam int BUDGET = 24;

   typedef struct {
      logic [W-1:0] raw;
      logic [W-1:0] db;
      logic [W-1:0] mask;
   } vec_t;

   typedef struct {
      logic [W-1:0] db;
      logic [W-1:0] mask;
   } exp_t;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic [W-1:0] raw_i = '0;
   logic [W-1:0] db_o;
   logic         chg_o;
   logic [W-1:0] chg_mask_o;

   exp_t         sb_q[$];
   int           checks   = 0;
   int           failures = 0;
   logic [W-1:0] cur_db   = '0;

   sw_debounce #(
      .WIDTH      (W),
      .STABLE_CNT (SC),
      .TICK_DIV   (TD)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .raw_i      (raw_i),
      .db_o       (db_o),
      .chg_o      (chg_o),
      .chg_mask_o (chg_mask_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Drive a raw value, push the expected update, then watch BUDGET edges.
   task automatic run_vec(input logic [W-1:0] raw, input logic [W-1:0] db,
                          input logic [W-1:0] mask, input string tag);
      int   pulses;
      exp_t e;
      pulses = 0;
      e.db   = db;
      e.mask = mask;
      raw_i  = raw;
      sb_q.push_back(e);
      for (int k = 1; k <= BUDGET; k++) begin
         step();
         if (chg_o) begin
            pulses++;
            if (sb_q.size() == 0) begin
               check({tag, "_spurious_chg"}, 32'(k), 32'(0));
            end else begin
               e = sb_q.pop_front();
               check({tag, "_db"}, 32'(db_o), 32'(e.db));
               check({tag, "_mask"}, 32'(chg_mask_o), 32'(e.mask));
               check({tag, "_lat_ok"}, 32'((k >= LO) && (k <= HI)), 32'(1));
               cur_db = e.db;
            end
         end else begin
            check({tag, "_hold_db"}, 32'(db_o), 32'(cur_db));
            check({tag, "_idle_mask"}, 32'(chg_mask_o), 32'(0));
         end
      end
      check({tag, "_pulses"}, 32'(pulses), 32'(1));
      check({tag, "_sb_left"}, 32'(sb_q.size()), 32'(0));
      if (sb_q.size() != 0) begin
         cur_db = db;
         sb_q.delete();
      end
   endtask

   initial begin
      vec_t vecs[8];
      vecs[0] = '{16'h0001, 16'h0001, 16'h0001};
      vecs[1] = '{16'h0000, 16'h0000, 16'h0001};
      vecs[2] = '{16'h8001, 16'h8001, 16'h8001};
      vecs[3] = '{16'h0F00, 16'h0F00, 16'h8F01};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 16'hF0FF};
      vecs[5] = '{16'h0000, 16'h0000, 16'hFFFF};
      vecs[6] = '{16'h0080, 16'h0080, 16'h0080};
      vecs[7] = '{16'h0000, 16'h0000, 16'h0080};

      // Reset held with all pads high: outputs stay cleared.
      raw_i = '1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("rst_db", 32'(db_o), 32'(0));
         check("rst_chg", 32'(chg_o), 32'(0));
         check("rst_mask", 32'(chg_mask_o), 32'(0));
      end
      raw_i = '0;
      step();
      rst_i = 1'b0;

      // Clean changes from the table.
      foreach (vecs[i]) run_vec(vecs[i].raw, vecs[i].db, vecs[i].mask, $sformatf("vec%0d", i));

      // Bounce: 3-high / 1-low bursts on bit 3 never pass.
      for (int b = 0; b < 5; b++) begin
         raw_i = 16'h0008;
         for (int k = 0; k < 3; k++) begin
            step();
            check("bounce_chg", 32'(chg_o), 32'(0));
            check("bounce_db", 32'(db_o), 32'(cur_db));
         end
         raw_i = '0;
         step();
         check("bounce_chg", 32'(chg_o), 32'(0));
         check("bounce_db", 32'(db_o), 32'(cur_db));
      end
      for (int k = 0; k < 8; k++) begin
         step();
         check("bounce_tail_chg", 32'(chg_o), 32'(0));
         check("bounce_tail_db", 32'(db_o), 32'(cur_db));
      end

      // Reset mid-count: bit 2 counting, then reset, then full re-debounce.
      raw_i = 16'h0004;
      step();
      step();
      step();
      rst_i = 1'b1;
      #1;
      check("rstmid_db", 32'(db_o), 32'(0));
      check("rstmid_chg", 32'(chg_o), 32'(0));
      step();
      step();
      check("rstmid_hold_db", 32'(db_o), 32'(0));
      check("rstmid_hold_chg", 32'(chg_o), 32'(0));
      rst_i  = 1'b0;
      cur_db = '0;
      run_vec(16'h0004, 16'h0004, 16'h0004, "rstmid");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
